// File: rtl/pe_feeder_pkg.sv
// pe_feeder_pkg: shared state encoding and data widths for the pe_feeder slice.
package pe_feeder_pkg;
    localparam int PIX_W  = 8;
    localparam int WIN_W  = 24;
    localparam int WORD_W = 32;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/pe_feeder_unpack.sv
// pe_feeder_unpack: holds one 4-pixel word and hands out one pixel per shift.
module pe_feeder_unpack
    import pe_feeder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] s_tdata,
    input  logic              s_tvalid,
    input  logic              en,
    input  logic              hold,
    output logic              s_tready,
    output logic [PIX_W-1:0]  px,
    output logic              shift,
    output logic              empty
);
    logic [WORD_W-1:0] data;
    logic [2:0]        left;
    logic              live;

    assign shift    = left != 3'd0 && !hold;
    assign empty    = left == 3'd0;
    assign px       = data[PIX_W-1:0];
    // ready one pixel early so the reload lands on the last shift edge
    assign s_tready = live && en && (empty || (left == 3'd1 && !hold));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            left <= '0;
            live <= 1'b0;
        end else begin
            live <= 1'b1;
            if (s_tvalid && s_tready) begin
                data <= s_tdata;
                left <= 3'd4;
            end else if (shift) begin
                data <= data >> PIX_W;
                left <= left - 3'd1;
            end
        end
    end
endmodule

// File: rtl/pe_feeder.sv
// pe_feeder: streams 32-bit pixel words into a row-bounded 3-pixel window.
// Define PE_FEEDER_ZERO_PAD_EN to pad each row with one zero pixel at both ends.
module pe_feeder
    import pe_feeder_pkg::*;
#(
    parameter int ROW_LEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] s_tdata,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    output logic              s_tready,
    output logic [WIN_W-1:0]  p,
    output logic              p_valid,
    output logic              frame_done,
    output logic              frame_err
);
`ifdef PE_FEEDER_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif
    localparam int            CW    = $clog2(ROW_LEN);
    localparam logic [CW-1:0] LAST  = CW'(ROW_LEN - 1);
    localparam logic [CW-1:0] FIRST = CW'(PAD ? 1 : 2);

    state_t            state_q, state_d;
    logic [CW-1:0]     col;
    logic [PIX_W-1:0]  px;
    logic              shift, empty, pad_pend, finish, hs;

    assign hs = s_tvalid && s_tready;

    pe_feeder_unpack u_unpack (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .en       (state_q != DRAIN),
        .hold     (pad_pend),
        .s_tready (s_tready),
        .px       (px),
        .shift    (shift),
        .empty    (empty)
    );

    always_comb begin
        state_d = state_q;
        finish  = 1'b0;
        if (state_q == DRAIN) begin
            finish = empty && !pad_pend;
            if (finish) state_d = IDLE;
        end else if (hs) begin
            state_d = s_tlast ? DRAIN : RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            p          <= '0;
            col        <= '0;
            p_valid    <= 1'b0;
            pad_pend   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_done <= finish;
            frame_err  <= finish && col != '0;
            if (shift) begin
                // with padding the row's first pixel enters behind an implicit zero
                p        <= (PAD && col == '0) ? {{(WIN_W-PIX_W){1'b0}}, px} : {p[WIN_W-PIX_W-1:0], px};
                col      <= col == LAST ? '0 : col + 1'b1;
                p_valid  <= col >= FIRST;
                pad_pend <= PAD && col == LAST;
            end else if (pad_pend) begin
                p        <= {p[WIN_W-PIX_W-1:0], {PIX_W{1'b0}}};
                p_valid  <= 1'b1;
                pad_pend <= 1'b0;
            end else begin
                p_valid <= 1'b0;
                if (finish) col <= '0;
            end
        end
    end
endmodule

// File: doc/pe_feeder.md
PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 Parameter ROW_LEN, default 8: pixels per image row; SHALL be a multiple of 4 and at least 4.
REQ-002 Port clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1: reset, asynchronous and active-high.
REQ-004 Port s_tdata  input  32: four 8-bit unsigned pixels; pixel order SHALL be [7:0] first, then [15:8], [23:16], [31:24].
REQ-005 Port s_tvalid  input  1: upstream word valid.
REQ-006 Port s_tlast  input  1: marks the last word of a frame.
REQ-007 Port s_tready  output  1: this block accepts a word.
REQ-008 Port p  output  24: 3-pixel window; [23:16] oldest, [15:8] middle, [7:0] newest pixel.
REQ-009 Port p_valid  output  1: p holds a valid window this cycle; there is no downstream backpressure.
REQ-010 Port frame_done  output  1: one-cycle pulse after the last window of a frame.
REQ-011 Port frame_err  output  1: one-cycle pulse on s_tlast misalignment.

Function
REQ-012 A word SHALL be accepted on an edge where s_tvalid and s_tready are both high; it SHALL be loaded into a 4-byte unpack register with a bytes-left count of 4.
REQ-013 Each cycle with bytes-left > 0, exactly one pixel SHALL shift into a 3-pixel window register, and bytes-left SHALL decrement.
REQ-014 s_tready SHALL be high when bytes-left is 0 or 1, so that a reload coincides with the last shift; steady-state throughput SHALL be one pixel per cycle.
REQ-015 Column counter: SHALL count 0..ROW_LEN-1 per shifted pixel and wrap to 0 at the end of the row.
REQ-016 p_valid SHALL be registered high on the shift edge of every pixel with column >= 2; the window SHALL never straddle a row boundary. This gives ROW_LEN-2 windows per row.
REQ-017 Latency: the first p_valid of a row SHALL appear 3 cycles after the handshake edge of the row's first word, given continuous s_tvalid.
REQ-018 If s_tvalid is low when reload is needed, shifting SHALL stall and p_valid SHALL be low; the window contents SHALL be held.
REQ-019 State machine IDLE -> RUN on the first handshake.
REQ-020 RUN -> DRAIN when a word with s_tlast is accepted; s_tready SHALL be low in DRAIN.
REQ-021 DRAIN -> IDLE after the final byte shifts; frame_done SHALL pulse on the cycle after the last p_valid.
REQ-022 If s_tlast arrives on a word that does not complete a row, frame_err SHALL pulse together with frame_done. The column counter SHALL clear and the next frame SHALL start at column 0.
REQ-023 All pixel values SHALL be passed unmodified; there is no arithmetic on data.

Reset
REQ-024 On rst, all outputs SHALL be 0, including s_tready, p, p_valid, frame_done and frame_err.
REQ-025 On rst, the state SHALL be IDLE and all counters and registers SHALL clear.
REQ-026 After rst deasserts, s_tready SHALL go high on the next cycle.
REQ-027 Reset mid-frame SHALL discard the partial word and window; no p_valid SHALL follow until a new frame starts.

Configuration
REQ-028 Macro PE_FEEDER_ZERO_PAD_EN, when defined, SHALL insert one zero pixel before and after each row. This gives ROW_LEN windows per row, and the first p_valid SHALL come 2 cycles after the handshake.
REQ-029 Without PE_FEEDER_ZERO_PAD_EN, there is no padding, per REQ-016.

Structure
REQ-030 A shared package SHALL hold the state encoding (IDLE/RUN/DRAIN), the pixel width (8), the window width (24) and the word width (32).
REQ-031 The byte unpacker (register, bytes-left count, s_tready logic) SHALL be a sub-module named pe_feeder_unpack; the window, column counter and FSM SHALL stay in the top.

Verification
REQ-032 ROW_LEN=8, one row of words 0x03020100 and 0x07060504 (last) with continuous valid -> p = 0x000102, 0x010203 .. 0x050607; 6 p_valid cycles, then frame_done; first p_valid at handshake+3.
REQ-033 Two rows back-to-back -> no window mixes pixel 7 of row 0 with pixel 0 of row 1; 12 windows in total.
REQ-034 s_tvalid dropped for 5 cycles mid-row -> p_valid low for those cycles; the window sequence is unchanged afterwards.
REQ-035 s_tlast on the first word of a row -> frame_err and frame_done pulse; the next frame's first window is its pixels 0..2.
REQ-036 rst asserted mid-row -> all outputs are 0 immediately; a fresh frame then produces the correct windows.
REQ-037 PE_FEEDER_ZERO_PAD_EN defined, same stimulus as REQ-032 -> first p = 0x000001, last p = 0x060700; 8 windows.
